vip_yuv422to444: RTL



---
 rtl/vip_pkg.sv | 12 +
 rtl/vip_sync_dly.sv | 29 ++
 rtl/vip_yuv422to444.sv | 112 +++++++++++
 3 files changed

// File: rtl/vip_pkg.sv
// Shared VIP definitions: component width, neutral chroma level and pixel-pair phase encoding.
package vip_pkg;

    localparam int unsigned VIP_BITS = 8;
    localparam logic [VIP_BITS-1:0] CHROMA_NEUTRAL = VIP_BITS'(1) << (VIP_BITS - 1);

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

endpackage

// File: rtl/vip_sync_dly.sv
// N-stage register delay for sync/strobe signals, synchronous active-high reset.
module vip_sync_dly #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < N; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[N-1];

endmodule

// File: rtl/vip_yuv422to444.sv
// YUV 4:2:2 to 4:4:4 chroma up-sampler: replicates each chroma pair across its two pixels,
// two cycles of latency on data, href and vsync.
module vip_yuv422to444
    import vip_pkg::*;
#(
    parameter int unsigned BITS = VIP_BITS
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            switch_uv,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_y,
    input  logic [BITS-1:0] in_c,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_y,
    output logic [BITS-1:0] out_u,
    output logic [BITS-1:0] out_v
);

    localparam logic [BITS-1:0] NEUTRAL = BITS'(1) << (BITS - 1);

    phase_t          ph;
    logic            href_d;
    logic            sw_lat;
    logic [BITS-1:0] s1_y;
    logic [BITS-1:0] s1_c;
    phase_t          s1_ph;
    logic            s1_href;
    logic            s1_sw;
    logic [BITS-1:0] hold;

    logic            line_start_c;
    logic            sw_eff_c;
    logic [BITS-1:0] first_c;
    logic [BITS-1:0] second_c;
    logic [BITS-1:0] u_c;
    logic [BITS-1:0] v_c;

    // The chroma order for a line is taken from switch_uv on its first active pixel.
    assign line_start_c = in_href & ~href_d;
    assign sw_eff_c     = line_start_c ? switch_uv : sw_lat;

    // A phase-0 pixel borrows its second chroma from the pixel now on the input.
    always_comb begin
        first_c  = s1_c;
        second_c = NEUTRAL;
        if (s1_ph == PH_FIRST) begin
            if (in_href && ph == PH_SECOND) begin
                second_c = in_c;
            end
        end else begin
            first_c  = hold;
            second_c = s1_c;
        end
        u_c = s1_sw ? second_c : first_c;
        v_c = s1_sw ? first_c  : second_c;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            ph      <= PH_FIRST;
            href_d  <= 1'b0;
            sw_lat  <= 1'b0;
            s1_y    <= '0;
            s1_c    <= '0;
            s1_ph   <= PH_FIRST;
            s1_href <= 1'b0;
            s1_sw   <= 1'b0;
            hold    <= '0;
            out_y   <= '0;
            out_u   <= '0;
            out_v   <= '0;
        end else begin
            href_d <= in_href;
            if (!in_href) begin
                ph <= PH_FIRST;
            end else begin
                ph <= (ph == PH_FIRST) ? PH_SECOND : PH_FIRST;
            end
            if (line_start_c) begin
                sw_lat <= switch_uv;
            end

            s1_y    <= in_y;
            s1_c    <= in_c;
            s1_ph   <= ph;
            s1_href <= in_href;
            s1_sw   <= sw_eff_c;

            if (s1_href && s1_ph == PH_FIRST) begin
                hold <= s1_c;
            end

            out_y <= s1_href ? s1_y : '0;
            out_u <= s1_href ? u_c  : '0;
            out_v <= s1_href ? v_c  : '0;
        end
    end

    vip_sync_dly #(
        .N (2),
        .W (2)
    ) u_sync_dly (
        .clk (pclk),
        .rst (rst),
        .d   ({in_href, in_vsync}),
        .q   ({out_href, out_vsync})
    );

endmodule
